cart_bus_arb: RTL and testbench

Two-port arbiter and sequencer for the single cartridge ROM/RAM bus. Port 0 serves the startup-screen logo reader; port 1 serves the CPU memory path. The block captures each port's request and grants the bus round-robin. It drives the cart strobe and enforces a minimum bus-cycle length, because cart_bsy alone cannot be trusted. It also times out hung accesses.

---
 rtl/cart_bus_arb.sv | 191 +++++++++++++++++++
 tb/tb_cart_bus_arb.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cart_bus_arb.sv
`timescale 1ns/1ps
// cart_bus_arb
//   Two-port arbiter and bus sequencer for the cartridge ROM/RAM bus.
//   Port 0 (logo reader) is read-only; port 1 (CPU path) reads and writes.
//   Each port's request is captured into a pending slot. The bus is granted
//   round-robin on ties. The strobe is issued for one cycle, and then a
//   minimum number of wait cycles is enforced before cart_bsy is believed.
//   Accesses that never see cart_bsy drop are forced complete after TIMEOUT
//   wait cycles. They return 8'hFF and raise a sticky timeout_err.
//
// Ports
//   clk_8m, rst          clock, synchronous active-high reset
//   p0_addr/p0_rd        port 0 read request (single-cycle pulse)
//   p0_data/p0_bsy       port 0 read data and busy (registered)
//   p1_addr/p1_rd/p1_wr  port 1 request (write wins if both pulse)
//   p1_wdata             port 1 write data, sampled with p1_wr
//   p1_data/p1_bsy       port 1 read data and busy (registered)
//   cart_addr/cart_wdata cartridge address / write data (held between cycles)
//   cart_rd/cart_wr      one-cycle cartridge strobes
//   cart_rdata/cart_bsy  cartridge read data / busy
//   timeout_err          sticky: some access timed out
module cart_bus_arb #(
    parameter int MIN_WAIT = 31,
    parameter int TIMEOUT  = 255
) (
    input  logic        clk_8m,
    input  logic        rst,
    input  logic [15:0] p0_addr,
    input  logic        p0_rd,
    output logic [7:0]  p0_data,
    output logic        p0_bsy,
    input  logic [15:0] p1_addr,
    input  logic        p1_rd,
    input  logic        p1_wr,
    input  logic [7:0]  p1_wdata,
    output logic [7:0]  p1_data,
    output logic        p1_bsy,
    output logic [15:0] cart_addr,
    output logic [7:0]  cart_wdata,
    output logic        cart_rd,
    output logic        cart_wr,
    input  logic [7:0]  cart_rdata,
    input  logic        cart_bsy,
    output logic        timeout_err
);

    localparam logic [7:0] MIN_M1 = 8'(MIN_WAIT - 1);
    localparam logic [7:0] TO_M1  = 8'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        ISSUE    = 2'd1,
        WAIT     = 2'd2,
        COMPLETE = 2'd3
    } state_t;

    state_t      state;
    logic [15:0] addr0_q;
    logic [15:0] addr1_q;
    logic [7:0]  wdata1_q;
    logic        wr1_q;
    logic        last_grant;
    logic        gnt_q;
    logic [7:0]  wait_cnt;
    logic        timed_out;

    logic        cap0;
    logic        cap1;
    logic        req0;
    logic        req1;
    logic        gnt_any;
    logic        gnt_sel;
    logic        wr1_eff;
    logic [15:0] addr0_eff;
    logic [15:0] addr1_eff;
    logic [7:0]  wdata1_eff;

    // pN_bsy doubles as the pending flag. It is set at capture and cleared
    // when the access completes. A request captured on this edge is merged
    // in here so that an idle bus can grant it immediately.
    always_comb begin
        cap0       = p0_rd & ~p0_bsy;
        cap1       = (p1_rd | p1_wr) & ~p1_bsy;
        req0       = p0_bsy | cap0;
        req1       = p1_bsy | cap1;
        addr0_eff  = cap0 ? p0_addr  : addr0_q;
        addr1_eff  = cap1 ? p1_addr  : addr1_q;
        wdata1_eff = cap1 ? p1_wdata : wdata1_q;
        wr1_eff    = cap1 ? p1_wr    : wr1_q;
        gnt_any    = req0 | req1;
        // On a tie, grant the port that was not granted on the last tie.
        if (req0 && req1) begin
            gnt_sel = ~last_grant;
        end else begin
            gnt_sel = req1;
        end
    end

    always_ff @(posedge clk_8m) begin
        if (rst) begin
            state       <= IDLE;
            p0_bsy      <= 1'b0;
            p1_bsy      <= 1'b0;
            p0_data     <= 8'h00;
            p1_data     <= 8'h00;
            cart_addr   <= 16'h0000;
            cart_wdata  <= 8'h00;
            cart_rd     <= 1'b0;
            cart_wr     <= 1'b0;
            timeout_err <= 1'b0;
            addr0_q     <= 16'h0000;
            addr1_q     <= 16'h0000;
            wdata1_q    <= 8'h00;
            wr1_q       <= 1'b0;
            last_grant  <= 1'b1;
            gnt_q       <= 1'b0;
            wait_cnt    <= 8'h00;
            timed_out   <= 1'b0;
        end else begin
            if (cap0) begin
                p0_bsy  <= 1'b1;
                addr0_q <= p0_addr;
            end
            if (cap1) begin
                p1_bsy   <= 1'b1;
                addr1_q  <= p1_addr;
                wdata1_q <= p1_wdata;
                wr1_q    <= p1_wr;
            end

            case (state)
                IDLE: begin
                    if (gnt_any) begin
                        state <= ISSUE;
                        gnt_q <= gnt_sel;
                        if (req0 && req1) begin
                            last_grant <= gnt_sel;
                        end
                        cart_addr <= gnt_sel ? addr1_eff : addr0_eff;
                        // Port 0 never writes, so cart_wdata keeps its last value.
                        if (gnt_sel) begin
                            cart_wdata <= wdata1_eff;
                        end
                        cart_rd <= ~(gnt_sel & wr1_eff);
                        cart_wr <= gnt_sel & wr1_eff;
                    end
                end

                ISSUE: begin
                    cart_rd  <= 1'b0;
                    cart_wr  <= 1'b0;
                    wait_cnt <= 8'h00;
                    state    <= WAIT;
                end

                WAIT: begin
                    if (wait_cnt != 8'hFF) begin
                        wait_cnt <= wait_cnt + 8'd1;
                    end
                    // cart_bsy is only trusted once the minimum wait has elapsed.
                    if (wait_cnt >= MIN_M1 && !cart_bsy) begin
                        state     <= COMPLETE;
                        timed_out <= 1'b0;
                    end else if (wait_cnt == TO_M1) begin
                        state     <= COMPLETE;
                        timed_out <= 1'b1;
                    end
                end

                COMPLETE: begin
                    if (!gnt_q) begin
                        p0_data <= timed_out ? 8'hFF : cart_rdata;
                        p0_bsy  <= 1'b0;
                    end else begin
                        if (!wr1_q) begin
                            p1_data <= timed_out ? 8'hFF : cart_rdata;
                        end
                        p1_bsy <= 1'b0;
                    end
                    if (timed_out) begin
                        timeout_err <= 1'b1;
                    end
                    state <= IDLE;
                end

                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_cart_bus_arb.sv
`timescale 1ns/1ps
// tb_cart_bus_arb
//   Directed stimulus for cart_bus_arb. Each request pushes its expected
//   strobe and completion into queues. A negedge monitor pops and compares
//   whenever the DUT strobes the cart bus or drops a port's busy flag.
module tb_cart_bus_arb;

    logic        clk_8m = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] p0_addr;
    logic        p0_rd;
    logic [7:0]  p0_data;
    logic        p0_bsy;
    logic [15:0] p1_addr;
    logic        p1_rd;
    logic        p1_wr;
    logic [7:0]  p1_wdata;
    logic [7:0]  p1_data;
    logic        p1_bsy;
    logic [15:0] cart_addr;
    logic [7:0]  cart_wdata;
    logic        cart_rd;
    logic        cart_wr;
    logic [7:0]  cart_rdata;
    logic        cart_bsy;
    logic        timeout_err;

    cart_bus_arb #(.MIN_WAIT(31), .TIMEOUT(255)) dut (
        .clk_8m      (clk_8m),
        .rst         (rst),
        .p0_addr     (p0_addr),
        .p0_rd       (p0_rd),
        .p0_data     (p0_data),
        .p0_bsy      (p0_bsy),
        .p1_addr     (p1_addr),
        .p1_rd       (p1_rd),
        .p1_wr       (p1_wr),
        .p1_wdata    (p1_wdata),
        .p1_data     (p1_data),
        .p1_bsy      (p1_bsy),
        .cart_addr   (cart_addr),
        .cart_wdata  (cart_wdata),
        .cart_rd     (cart_rd),
        .cart_wr     (cart_wr),
        .cart_rdata  (cart_rdata),
        .cart_bsy    (cart_bsy),
        .timeout_err (timeout_err)
    );

    always #5 clk_8m = ~clk_8m;

    int cyc = 0;
    always @(posedge clk_8m) cyc <= cyc + 1;

    logic rst_q = 1'b1;
    always @(posedge clk_8m) rst_q <= rst;

    // Cart model: fixed data, or an address-derived pattern.
    logic       mode = 1'b0;
    logic [7:0] fixed_rdata = 8'h00;
    assign cart_rdata = mode ? (cart_addr[15:8] ^ cart_addr[7:0] ^ 8'h3C) : fixed_rdata;

    typedef struct {
        int          cyc;
        logic        wr;
        logic [15:0] addr;
        logic [7:0]  wdata;
    } strobe_t;

    typedef struct {
        int         cyc;
        logic       port;
        logic [7:0] data;
        logic       terr;
    } cmpl_t;

    strobe_t sq[$];
    cmpl_t   cq[$];
    strobe_t mon_s;
    cmpl_t   mon_c;
    logic    prev_b0;
    logic    prev_b1;

    int vectors = 0;
    int miscompares = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, want 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic check_cmpl(input logic port, input logic [7:0] data);
        if (cq.size() == 0) begin
            chk("unexpected_completion", 32'd1, 32'd0);
        end else begin
            mon_c = cq.pop_front();
            chk("cmpl_port", {31'd0, port}, {31'd0, mon_c.port});
            chk("cmpl_cycle", cyc, mon_c.cyc);
            chk("cmpl_data", {24'd0, data}, {24'd0, mon_c.data});
            chk("cmpl_timeout_err", {31'd0, timeout_err}, {31'd0, mon_c.terr});
        end
    endtask

    always @(negedge clk_8m) begin
        if (cart_rd === 1'b1 || cart_wr === 1'b1) begin
            if (sq.size() == 0) begin
                chk("unexpected_strobe", 32'd1, 32'd0);
            end else begin
                mon_s = sq.pop_front();
                chk("strobe_cycle", cyc, mon_s.cyc);
                chk("strobe_kind", {30'd0, cart_wr, cart_rd}, {30'd0, mon_s.wr, ~mon_s.wr});
                chk("strobe_addr", {16'd0, cart_addr}, {16'd0, mon_s.addr});
                if (mon_s.wr) begin
                    chk("strobe_wdata", {24'd0, cart_wdata}, {24'd0, mon_s.wdata});
                end
            end
        end
        if (prev_b0 === 1'b1 && p0_bsy === 1'b0 && !rst_q) check_cmpl(1'b0, p0_data);
        if (prev_b1 === 1'b1 && p1_bsy === 1'b0 && !rst_q) check_cmpl(1'b1, p1_data);
        prev_b0 = p0_bsy;
        prev_b1 = p1_bsy;
    end

    task automatic push_s(input int c, input logic wr, input logic [15:0] a, input logic [7:0] wd);
        strobe_t s;
        s.cyc = c; s.wr = wr; s.addr = a; s.wdata = wd;
        sq.push_back(s);
    endtask

    task automatic push_c(input int c, input logic port, input logic [7:0] d, input logic terr);
        cmpl_t e;
        e.cyc = c; e.port = port; e.data = d; e.terr = terr;
        cq.push_back(e);
    endtask

    // One-cycle request pulse; t returns the cycle the pulse was high.
    task automatic pulse(input logic do0, input logic [15:0] a0, input logic r1, input logic w1,
                         input logic [15:0] a1, input logic [7:0] wd, output int t);
        @(posedge clk_8m); #1;
        p0_rd = do0; p0_addr = a0;
        p1_rd = r1; p1_wr = w1; p1_addr = a1; p1_wdata = wd;
        t = cyc;
        @(posedge clk_8m); #1;
        p0_rd = 1'b0; p1_rd = 1'b0; p1_wr = 1'b0;
    endtask

    task automatic wait_until(input int target);
        while (cyc < target) begin
            @(posedge clk_8m); #1;
        end
    endtask

    task automatic wait_idle(input int max);
        int n = 0;
        while ((sq.size() != 0 || cq.size() != 0) && n < max) begin
            @(posedge clk_8m);
            n++;
        end
        if (sq.size() != 0 || cq.size() != 0) begin
            chk("drain_timeout", sq.size() + cq.size(), 32'd0);
            sq.delete();
            cq.delete();
        end
        repeat (3) @(posedge clk_8m);
        #1;
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_p0_data"}, {24'd0, p0_data}, 32'd0);
        chk({tag, "_p1_data"}, {24'd0, p1_data}, 32'd0);
        chk({tag, "_p0_bsy"}, {31'd0, p0_bsy}, 32'd0);
        chk({tag, "_p1_bsy"}, {31'd0, p1_bsy}, 32'd0);
        chk({tag, "_cart_addr"}, {16'd0, cart_addr}, 32'd0);
        chk({tag, "_cart_wdata"}, {24'd0, cart_wdata}, 32'd0);
        chk({tag, "_cart_rd"}, {31'd0, cart_rd}, 32'd0);
        chk({tag, "_cart_wr"}, {31'd0, cart_wr}, 32'd0);
        chk({tag, "_timeout_err"}, {31'd0, timeout_err}, 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got cycle %0d want < 20000", cyc);
        $fatal(1);
    end

    initial begin
        int t;
        p0_addr = 16'h0; p0_rd = 1'b0;
        p1_addr = 16'h0; p1_rd = 1'b0; p1_wr = 1'b0; p1_wdata = 8'h0;
        cart_bsy = 1'b0;

        rst = 1'b1;
        repeat (3) @(posedge clk_8m);
        #1 rst = 1'b0;
        @(negedge clk_8m);
        check_all_zero("reset");

        // Uncontended read: strobe at T+1, data at T+34.
        mode = 1'b0; fixed_rdata = 8'hCE;
        pulse(1'b1, 16'h0104, 1'b0, 1'b0, 16'h0, 8'h0, t);
        push_s(t + 1, 1'b0, 16'h0104, 8'h00);
        push_c(t + 34, 1'b0, 8'hCE, 1'b0);
        wait_idle(100);

        // Tie with last_grant=1 after reset: port 0 first, then port 1.
        mode = 1'b1;
        pulse(1'b1, 16'h1234, 1'b1, 1'b0, 16'h2345, 8'h0, t);
        push_s(t + 1, 1'b0, 16'h1234, 8'h00);
        push_c(t + 34, 1'b0, 8'h1A, 1'b0);
        push_s(t + 35, 1'b0, 16'h2345, 8'h00);
        push_c(t + 68, 1'b1, 8'h5A, 1'b0);
        wait_idle(150);

        // Second tie: port 1 wins this time.
        pulse(1'b1, 16'h00FF, 1'b1, 1'b0, 16'h2345, 8'h0, t);
        push_s(t + 1, 1'b0, 16'h2345, 8'h00);
        push_c(t + 34, 1'b1, 8'h5A, 1'b0);
        push_s(t + 35, 1'b0, 16'h00FF, 8'h00);
        push_c(t + 68, 1'b0, 8'hC3, 1'b0);
        wait_idle(150);

        // Port 1 rd+wr together: the write wins, and p1_data keeps 0x5A.
        pulse(1'b0, 16'h0, 1'b1, 1'b1, 16'h2000, 8'h05, t);
        push_s(t + 1, 1'b1, 16'h2000, 8'h05);
        push_c(t + 34, 1'b1, 8'h5A, 1'b0);
        wait_idle(100);
        chk("hold_cart_addr", {16'd0, cart_addr}, 32'h2000);
        chk("hold_cart_wdata", {24'd0, cart_wdata}, 32'h05);

        // cart_bsy held 10 cycles past the minimum: completion is 10 cycles later.
        mode = 1'b0; fixed_rdata = 8'h77; cart_bsy = 1'b1;
        pulse(1'b1, 16'h0300, 1'b0, 1'b0, 16'h0, 8'h0, t);
        push_s(t + 1, 1'b0, 16'h0300, 8'h00);
        push_c(t + 44, 1'b0, 8'h77, 1'b0);
        wait_until(t + 42);
        cart_bsy = 1'b0;
        wait_idle(100);

        // cart_bsy stuck: timeout at WAIT cycle 255, data 0xFF, sticky flag.
        cart_bsy = 1'b1;
        pulse(1'b1, 16'h0400, 1'b0, 1'b0, 16'h0, 8'h0, t);
        push_s(t + 1, 1'b0, 16'h0400, 8'h00);
        push_c(t + 258, 1'b0, 8'hFF, 1'b1);
        wait_until(t + 257);
        @(negedge clk_8m);
        chk("terr_before_timeout", {31'd0, timeout_err}, 32'd0);
        wait_idle(100);
        cart_bsy = 1'b0;
        mode = 1'b1;
        pulse(1'b0, 16'h0, 1'b1, 1'b0, 16'h3456, 8'h0, t);
        push_s(t + 1, 1'b0, 16'h3456, 8'h00);
        push_c(t + 34, 1'b1, 8'h5E, 1'b1);
        wait_idle(100);

        // rst during WAIT aborts the access; no strobe or completion follows.
        mode = 1'b0; fixed_rdata = 8'hCE;
        pulse(1'b1, 16'h0500, 1'b0, 1'b0, 16'h0, 8'h0, t);
        push_s(t + 1, 1'b0, 16'h0500, 8'h00);
        wait_until(t + 10);
        rst = 1'b1;
        @(posedge clk_8m); #1;
        rst = 1'b0;
        repeat (40) @(posedge clk_8m);
        @(negedge clk_8m);
        check_all_zero("after_rst");
        chk("after_rst_queue", sq.size() + cq.size(), 32'd0);

        // A normal request after the abort.
        pulse(1'b1, 16'h0104, 1'b0, 1'b0, 16'h0, 8'h0, t);
        push_s(t + 1, 1'b0, 16'h0104, 8'h00);
        push_c(t + 34, 1'b0, 8'hCE, 1'b0);
        wait_idle(100);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
